// File: rtl/rv32i_multicycle_controller_pkg.sv
// Shared types for the multicycle RV32I control unit: FSM states, datapath
// select encodings, ALU operations, opcode constants and branch resolution.
package rv32i_multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_TGT  = 4'd11,
        S_LUI       = 4'd12,
        S_AUIPC     = 4'd13
    } ctrl_state_t;

    typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLD_PC, SRC_A_REG, SRC_A_ZERO} alu_src_a_t;
    typedef enum logic [1:0] {SRC_B_REG, SRC_B_IMM, SRC_B_FOUR} alu_src_b_t;
    typedef enum logic [1:0] {RES_ALU_OUT, RES_DATA, RES_ALU_RESULT} res_src_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_BRANCH, ALUOP_FUNCT} alu_op_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_control_t;

    // Branch compare runs SUB (BEQ/BNE) or SLT/SLTU (others); funct3 01x is reserved.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic lsb);
        case (funct3)
            3'b000:          return zero;
            3'b001:          return !zero;
            3'b100, 3'b110:  return lsb;
            3'b101, 3'b111:  return !lsb;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's coarse ALU op plus instruction fields to
// a concrete ALU operation. Purely combinational.
module rv32i_alu_decoder
    import rv32i_multicycle_controller_pkg::*;
(
    input  alu_op_t      alu_op_i,
    input  logic [2:0]   funct3_i,
    input  logic         op5_i,
    input  logic         funct7b5_i,
    output alu_control_t alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_control_o = ALU_SLT;
                    2'b11:   alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                // op[5] separates R-type SUB from ADDI, whose imm may set bit 30.
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath.
module rv32i_multicycle_controller
    import rv32i_multicycle_controller_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic         zero,
    input  logic         alu_lsb,
    output logic         pc_write,
    output logic         adr_src,
    output logic         mem_write,
    output logic         ir_write,
    output logic         reg_write,
    output alu_src_a_t   alu_src_a,
    output alu_src_b_t   alu_src_b,
    output res_src_t     res_src,
    output imm_src_t     imm_src,
    output alu_control_t alu_control,
    output logic         illegal,
    output logic [3:0]   state_dbg
);

    ctrl_state_t state_q, state_d;
    alu_op_t     aluOp;
    logic        pcWr, memWr, irWr, regWr, illegalRaw;
    logic        wrEn;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_FETCH;
        else if (ena)
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pcWr       = 1'b0;
        memWr      = 1'b0;
        irWr       = 1'b0;
        regWr      = 1'b0;
        illegalRaw = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        res_src    = RES_ALU_RESULT;
        aluOp      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                irWr    = 1'b1;
                pcWr    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_TGT;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        illegalRaw = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                state_d   = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                res_src = RES_ALU_OUT;
                adr_src = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                res_src = RES_DATA;
                regWr   = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                res_src = RES_ALU_OUT;
                adr_src = 1'b1;
                memWr   = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = (state_q == S_EXEC_R) ? SRC_B_REG : SRC_B_IMM;
                aluOp     = ALUOP_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_LUI, S_AUIPC: begin
                alu_src_a = (state_q == S_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                res_src = RES_ALU_OUT;
                regWr   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                aluOp     = ALUOP_BRANCH;
                res_src   = RES_ALU_OUT;
                pcWr      = branch_taken(funct3, zero, alu_lsb);
                state_d   = S_FETCH;
            end
            S_JALR_TGT: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // alu_out holds the jump target; the ALU forms the link address.
                alu_src_a = SRC_A_OLD_PC;
                res_src   = RES_ALU_OUT;
                pcWr      = 1'b1;
                state_d   = S_ALU_WB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

    rv32i_alu_decoder u_alu_decoder (
        .alu_op_i      (aluOp),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

    // Stalls and reset suppress every side effect but leave selects visible.
    assign wrEn      = ena && !rst;
    assign pc_write  = pcWr && wrEn;
    assign mem_write = memWr && wrEn;
    assign ir_write  = irWr && wrEn;
    assign reg_write = regWr && wrEn;
    assign illegal   = illegalRaw && wrEn;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed self-checking bench for the multicycle RV32I controller.
module tb_rv32i_multicycle_controller;
    import rv32i_multicycle_controller_pkg::*;

    logic         clk = 1'b0;
    logic         rst, ena;
    logic [6:0]   op;
    logic [2:0]   funct3;
    logic         funct7b5, zero, alu_lsb;
    logic         pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    alu_src_a_t   alu_src_a;
    alu_src_b_t   alu_src_b;
    res_src_t     res_src;
    imm_src_t     imm_src;
    alu_control_t alu_control;
    logic [3:0]   state_dbg;

    int checkCount = 0;
    int failCount  = 0;

    rv32i_multicycle_controller dut (
        .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .alu_lsb(alu_lsb),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .res_src(res_src), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        #0;
    endtask

    // Checks FETCH outputs then advances through FETCH into DECODE.
    task automatic fetchDecode(input string tag);
        checkOutput({tag, "_fetch_state"}, state_dbg, S_FETCH);
        checkOutput({tag, "_fetch_ir"}, ir_write, 1);
        checkOutput({tag, "_fetch_pc"}, pc_write, 1);
        step();
        checkOutput({tag, "_decode_state"}, state_dbg, S_DECODE);
        step();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; zero = 1'b0; alu_lsb = 1'b0;
        applyStimulus(OP_LOAD, 3'b010, 1'b0);
        step();
        checkOutput("rst_state", state_dbg, S_FETCH);
        checkOutput("rst_pc", pc_write, 0);
        checkOutput("rst_ir", ir_write, 0);
        rst = 1'b0;
        #1;

        // lw: 5 cycles, reg_write only in MEM_WB with DATA
        checkOutput("lw_fetch_adr", adr_src, 0);
        checkOutput("lw_fetch_srca", alu_src_a, SRC_A_PC);
        checkOutput("lw_fetch_srcb", alu_src_b, SRC_B_FOUR);
        checkOutput("lw_fetch_res", res_src, RES_ALU_RESULT);
        checkOutput("lw_fetch_alu", alu_control, ALU_ADD);
        step();
        checkOutput("lw_dec_state", state_dbg, S_DECODE);
        checkOutput("lw_dec_srca", alu_src_a, SRC_A_OLD_PC);
        checkOutput("lw_dec_srcb", alu_src_b, SRC_B_IMM);
        checkOutput("lw_dec_imm", imm_src, IMM_I);
        checkOutput("lw_dec_illegal", illegal, 0);
        step();
        checkOutput("lw_adr_state", state_dbg, S_MEM_ADR);
        checkOutput("lw_adr_srca", alu_src_a, SRC_A_REG);
        step();
        checkOutput("lw_rd_state", state_dbg, S_MEM_READ);
        checkOutput("lw_rd_adr", adr_src, 1);
        checkOutput("lw_rd_regw", reg_write, 0);
        step();
        checkOutput("lw_wb_state", state_dbg, S_MEM_WB);
        checkOutput("lw_wb_regw", reg_write, 1);
        checkOutput("lw_wb_res", res_src, RES_DATA);
        step();
        checkOutput("lw_done_state", state_dbg, S_FETCH);

        // sub / sra
        applyStimulus(OP_R, 3'b000, 1'b1);
        fetchDecode("sub");
        checkOutput("sub_exec_state", state_dbg, S_EXEC_R);
        checkOutput("sub_exec_alu", alu_control, ALU_SUB);
        checkOutput("sub_exec_srcb", alu_src_b, SRC_B_REG);
        applyStimulus(OP_R, 3'b101, 1'b1);
        checkOutput("sra_exec_alu", alu_control, ALU_SRA);
        step();
        checkOutput("sub_wb_state", state_dbg, S_ALU_WB);
        checkOutput("sub_wb_regw", reg_write, 1);
        step();
        checkOutput("sub_done_state", state_dbg, S_FETCH);

        // addi with bit 30 set must stay ADD
        applyStimulus(OP_I, 3'b000, 1'b1);
        fetchDecode("addi");
        checkOutput("addi_exec_state", state_dbg, S_EXEC_I);
        checkOutput("addi_exec_alu", alu_control, ALU_ADD);
        checkOutput("addi_exec_srcb", alu_src_b, SRC_B_IMM);
        step(); step();

        // lui
        applyStimulus(OP_LUI, 3'b000, 1'b0);
        checkOutput("lui_imm", imm_src, IMM_U);
        fetchDecode("lui");
        checkOutput("lui_state", state_dbg, S_LUI);
        checkOutput("lui_srca", alu_src_a, SRC_A_ZERO);
        step(); step();

        // branches
        applyStimulus(OP_BRANCH, 3'b000, 1'b0);
        zero = 1'b1;
        fetchDecode("beq");
        checkOutput("beq_state", state_dbg, S_BRANCH);
        checkOutput("beq_imm", imm_src, IMM_B);
        checkOutput("beq_taken_pc", pc_write, 1);
        checkOutput("beq_alu", alu_control, ALU_SUB);
        zero = 1'b0; #1;
        checkOutput("beq_nottaken_pc", pc_write, 0);
        applyStimulus(OP_BRANCH, 3'b101, 1'b0);
        alu_lsb = 1'b0; #1;
        checkOutput("bge_taken_pc", pc_write, 1);
        checkOutput("bge_alu", alu_control, ALU_SLT);
        alu_lsb = 1'b1; #1;
        checkOutput("bge_nottaken_pc", pc_write, 0);
        applyStimulus(OP_BRANCH, 3'b010, 1'b0);
        alu_lsb = 1'b0; #1;
        checkOutput("b010_pc", pc_write, 0);
        step();
        checkOutput("br_done_state", state_dbg, S_FETCH);

        // jalr: 5 cycles
        applyStimulus(OP_JALR, 3'b000, 1'b0);
        fetchDecode("jalr");
        checkOutput("jalr_tgt_state", state_dbg, S_JALR_TGT);
        checkOutput("jalr_tgt_srca", alu_src_a, SRC_A_REG);
        checkOutput("jalr_tgt_pc", pc_write, 0);
        step();
        checkOutput("jalr_jal_state", state_dbg, S_JAL);
        checkOutput("jalr_jal_pc", pc_write, 1);
        checkOutput("jalr_jal_res", res_src, RES_ALU_OUT);
        checkOutput("jalr_jal_srca", alu_src_a, SRC_A_OLD_PC);
        step();
        checkOutput("jalr_wb_state", state_dbg, S_ALU_WB);
        checkOutput("jalr_wb_regw", reg_write, 1);
        step();
        checkOutput("jalr_done_state", state_dbg, S_FETCH);

        // store with 3-cycle stall in MEM_WRITE
        applyStimulus(OP_STORE, 3'b010, 1'b0);
        checkOutput("sw_imm", imm_src, IMM_S);
        fetchDecode("sw");
        step();
        checkOutput("sw_wr_state", state_dbg, S_MEM_WRITE);
        ena = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sw_stall_memw", mem_write, 0);
            checkOutput("sw_stall_adr", adr_src, 1);
            step();
            checkOutput("sw_stall_state", state_dbg, S_MEM_WRITE);
        end
        ena = 1'b1; #1;
        checkOutput("sw_resume_memw", mem_write, 1);
        step();
        checkOutput("sw_done_state", state_dbg, S_FETCH);
        checkOutput("sw_done_memw", mem_write, 0);

        // illegal opcode
        applyStimulus(7'b1111111, 3'b000, 1'b0);
        checkOutput("ill_fetch_illegal", illegal, 0);
        step();
        checkOutput("ill_dec_illegal", illegal, 1);
        checkOutput("ill_dec_regw", reg_write, 0);
        checkOutput("ill_dec_pc", pc_write, 0);
        checkOutput("ill_dec_ir", ir_write, 0);
        checkOutput("ill_dec_memw", mem_write, 0);
        step();
        checkOutput("ill_next_state", state_dbg, S_FETCH);
        checkOutput("ill_next_illegal", illegal, 0);

        // reset while in MEM_WB
        applyStimulus(OP_LOAD, 3'b010, 1'b0);
        fetchDecode("rstlw");
        step(); step();
        checkOutput("rstlw_wb_state", state_dbg, S_MEM_WB);
        rst = 1'b1; #1;
        checkOutput("rstlw_wb_regw", reg_write, 0);
        step();
        checkOutput("rstlw_state", state_dbg, S_FETCH);
        checkOutput("rstlw_ir", ir_write, 0);
        checkOutput("rstlw_pc", pc_write, 0);
        rst = 1'b0; #1;
        checkOutput("rstlw_release_ir", ir_write, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        failCount++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
